// File: rtl/inst_prefetch.sv
// Instruction-byte prefetcher: fetch PC drives a combinational ROM, bytes queue in a small FIFO.
// One cycle fetch-to-output latency; fetch stalls when full unless the head pops the same cycle.

module prefetch_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wr_dat,
  output logic [W-1:0]  rd_dat,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign empty  = (level == '0);
  assign full   = (level == LW'(DEPTH));
  assign rd_dat = mem[rd_ptr];

  // Storage needs no reset: the head is only observed while level is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

module inst_prefetch #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0,
  parameter int LW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ready,
  output logic [LW-1:0]     fifo_level
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } ent_t;

  logic [ADDR_W-1:0] fetch_pc;
  ent_t              wr_ent;
  ent_t              head;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  // A jump wins over any handshake: the head stays unconsumed and is flushed.
  assign pop  = !empty && inst_ready && !jump_valid;
  assign push = fetch_en && !jump_valid && (!full || pop);

  assign wr_ent.addr = fetch_pc;
  assign wr_ent.dat  = rom_data;

  prefetch_fifo #(
    .W     ($bits(ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (jump_valid),
    .push    (push),
    .pop     (pop),
    .wr_dat  (wr_ent),
    .rd_dat  (head),
    .empty   (empty),
    .full    (full),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= ADDR_W'(RESET_PC);
    end else if (jump_valid) begin
      fetch_pc <= jump_addr;
    end else if (push) begin
      fetch_pc <= fetch_pc + 1'b1;
    end
  end

  assign rom_addr   = fetch_pc;
  assign inst_valid = !empty;
  assign inst_data  = empty ? '0 : head.dat;
  assign inst_addr  = empty ? '0 : head.addr;

endmodule

// File: tb/tb_inst_prefetch.sv
// Randomized and directed bench for inst_prefetch against a queue-based reference model.
module tb_inst_prefetch;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int NADDR  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              fetch_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_addr;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ready;
  logic [2:0]        fifo_level;

  logic [DATA_W-1:0] rom [NADDR];
  assign rom_data = rom[rom_addr];

  inst_prefetch #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RESET_PC (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fetch_en   (fetch_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .jump_valid (jump_valid),
    .jump_addr  (jump_addr),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_addr  (inst_addr),
    .inst_ready (inst_ready),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of fetched (address, byte) pairs and the next fetch address.
  int m_addr_q[$];
  int m_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    int exp_addr;
    exp_addr = (m_addr_q.size() > 0) ? m_addr_q[0] : 0;
    chk("valid", 32'(inst_valid), (m_addr_q.size() > 0) ? 1 : 0);
    chk("level", 32'(fifo_level), m_addr_q.size());
    chk("rom_addr", 32'(rom_addr), m_pc);
    chk("inst_addr", 32'(inst_addr), exp_addr);
    chk("inst_data", 32'(inst_data), (m_addr_q.size() > 0) ? 32'(rom[exp_addr]) : 0);
  endtask

  task automatic model_reset();
    m_addr_q.delete();
    m_pc = 0;
  endtask

  // Called at a falling edge: check, drive, advance the model, wait for next falling edge.
  task automatic step(input logic fen, input logic jv, input int ja, input logic rdy);
    bit do_pop;
    bit do_push;
    check_outputs();
    fetch_en   = fen;
    jump_valid = jv;
    jump_addr  = ADDR_W'(ja);
    inst_ready = rdy;
    if (jv) begin
      m_addr_q.delete();
      m_pc = ja % NADDR;
    end else begin
      do_pop  = (m_addr_q.size() > 0) && rdy;
      do_push = fen && ((m_addr_q.size() < DEPTH) || do_pop);
      if (do_pop)  void'(m_addr_q.pop_front());
      if (do_push) begin
        m_addr_q.push_back(m_pc);
        m_pc = (m_pc + 1) % NADDR;
      end
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(inst_valid), 0);
    chk("arst_level", 32'(fifo_level), 0);
    chk("arst_rom_addr", 32'(rom_addr), 0);
    chk("arst_data", 32'(inst_data), 0);
    @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NADDR; i++) rom[i] = DATA_W'($urandom);
    rom[0] = 8'hc0;
    rom[1] = 8'h04;
    rom[2] = 8'h70;

    reset_n    = 1'b0;
    fetch_en   = 1'b1;
    jump_valid = 1'b0;
    jump_addr  = '0;
    inst_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;

    // Free-running from reset: c0/0, 04/1, 70/2.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 1'b1);

    // Fill until full, then drain while fetching continues.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 1'b1);

    // Jump while full with a handshake in the same cycle.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 'h020, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 1'b1);

    // Wrap of the fetch PC.
    step(1'b1, 1'b1, 'hffe, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 1'b1);

    // Three queued bytes, then fetch stalled while draining.
    step(1'b0, 1'b1, 'h100, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 1'b1);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0);
    async_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0),
           int'($urandom_range(0, NADDR - 1)),
           ($urandom_range(0, 1) == 1));
      if (i == 1500) async_reset();
    end
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
